// File: rtl/mul_iter_unit.sv
// rtl/mul_iter_unit.sv - iterative shift-add MUL/MLA unit, one multiplier bit per clock
// Optional early exit once the remaining multiplier bits are zero: define MUL_EARLY_TERM_EN.
module mul_iter_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              accumulate,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] acc,
    input  logic [3:0]        wa_in,
    output logic              busy,
    output logic              done,
    output logic              we_out,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        wa_out,
    output logic              flag_n,
    output logic              flag_z
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplr_q, mplr_d;
    logic [DATA_W-1:0] prod_q, prod_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        wa_q, wa_d;
    logic              flag_n_q, flag_n_d;
    logic              flag_z_q, flag_z_d;
    logic [DATA_W-1:0] hold_result_q, hold_result_d;
    logic              hold_n_q, hold_n_d;
    logic              hold_z_q, hold_z_d;
    logic [DATA_W-1:0] prod_next;
    logic              last_bit;

    always_comb begin
        prod_next = mplr_q[0] ? prod_q + mcand_q : prod_q;
`ifdef MUL_EARLY_TERM_EN
        last_bit  = (cnt_q == CNT_W'(DATA_W-1)) || (mplr_q[DATA_W-1:1] == '0);
`else
        last_bit  = (cnt_q == CNT_W'(DATA_W-1));
`endif
        state_d       = state_q;
        cnt_d         = cnt_q;
        mcand_d       = mcand_q;
        mplr_d        = mplr_q;
        prod_d        = prod_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        result_d      = result_q;
        wa_d          = wa_q;
        flag_n_d      = flag_n_q;
        flag_z_d      = flag_z_q;
        hold_result_d = hold_result_q;
        hold_n_d      = hold_n_q;
        hold_z_d      = hold_z_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    mcand_d = a;
                    mplr_d  = b;
                    prod_d  = accumulate ? acc : '0;
                    wa_d    = wa_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    prod_d  = prod_next;
                    mcand_d = mcand_q << 1;
                    mplr_d  = mplr_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        // Old result is kept aside so an abort during DONE can put it back.
                        hold_result_d = result_q;
                        hold_n_d      = flag_n_q;
                        hold_z_d      = flag_z_q;
                        result_d      = prod_next;
                        flag_n_d      = prod_next[DATA_W-1];
                        flag_z_d      = (prod_next == '0);
                        done_d        = 1'b1;
                        state_d       = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (abort) begin
                    result_d = hold_result_q;
                    flag_n_d = hold_n_q;
                    flag_z_d = hold_z_q;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            mcand_q       <= '0;
            mplr_q        <= '0;
            prod_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            wa_q          <= '0;
            flag_n_q      <= 1'b0;
            flag_z_q      <= 1'b0;
            hold_result_q <= '0;
            hold_n_q      <= 1'b0;
            hold_z_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mcand_q       <= mcand_d;
            mplr_q        <= mplr_d;
            prod_q        <= prod_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            result_q      <= result_d;
            wa_q          <= wa_d;
            flag_n_q      <= flag_n_d;
            flag_z_q      <= flag_z_d;
            hold_result_q <= hold_result_d;
            hold_n_q      <= hold_n_d;
            hold_z_q      <= hold_z_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q & ~abort;
    assign we_out = done_q & ~abort;
    assign result = result_q;
    assign wa_out = wa_q;
    assign flag_n = flag_n_q;
    assign flag_z = flag_z_q;
endmodule

// File: tb/tb_mul_iter_unit.sv
// tb/tb_mul_iter_unit.sv - self-checking bench for mul_iter_unit (vector table, corner sequences, random ops)
module tb_mul_iter_unit;
`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, start, abort, accumulate;
    logic [31:0] a, b, acc;
    logic [3:0]  wa_in;
    logic        busy, done, we_out, flag_n, flag_z;
    logic [31:0] result;
    logic [3:0]  wa_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] last_res = '0;
    logic        last_n = 1'b0, last_z = 1'b0;

    always #5 clk = ~clk;

    mul_iter_unit #(.DATA_W(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .accumulate(accumulate),
        .a(a), .b(b), .acc(acc), .wa_in(wa_in), .busy(busy), .done(done), .we_out(we_out),
        .result(result), .wa_out(wa_out), .flag_n(flag_n), .flag_z(flag_z)
    );

    typedef struct {
        logic [31:0] a, b, acc;
        logic        accum;
        logic [3:0]  wa;
        logic [31:0] exp_res;
        logic        exp_n, exp_z;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [31:0] z, input logic use_acc);
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        return p[31:0] + (use_acc ? z : 32'd0);
    endfunction

    function automatic int exp_cycle(input logic [31:0] y);
        int m;
        if (!EARLY) return 33;
        m = 0;
        for (int i = 0; i < 32; i++) if (y[i]) m = i;
        return m + 2;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic scramble();
        a = $urandom; b = $urandom; acc = $urandom;
        wa_in = 4'($urandom); accumulate = 1'($urandom);
    endtask

    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                            input logic use_acc, input logic [3:0] w);
        a = x; b = y; acc = z; accumulate = use_acc; wa_in = w; start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        scramble();
    endtask

    task automatic finish_op(input string name, input int ec, input logic [31:0] er,
                             input logic en, input logic ez, input logic [3:0] w);
        while (!done && cyc < 40) begin
            scramble();
            step();
        end
        check({name, ".done_cycle"}, 64'(cyc), 64'(ec));
        check({name, ".result"}, 64'(result), 64'(er));
        check({name, ".flags"}, 64'({flag_n, flag_z}), 64'({en, ez}));
        check({name, ".wa_out"}, 64'(wa_out), 64'(w));
        check({name, ".we_out"}, 64'(we_out), 64'(1'b1));
        step();
        check({name, ".one_cycle_done"}, 64'({done, we_out, busy}), 64'(0));
        last_res = er; last_n = en; last_z = ez;
    endtask

    task automatic run_op(input string name, input vec_t v);
        start_op(v.a, v.b, v.acc, v.accum, v.wa);
        check({name, ".busy"}, 64'(busy), 64'(1'b1));
        finish_op(name, exp_cycle(v.b), v.exp_res, v.exp_n, v.exp_z, v.wa);
    endtask

    task automatic expect_quiet(input string name, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (done || we_out || busy) seen++;
        end
        check({name, ".quiet"}, 64'(seen), 64'(0));
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = '{32'd7, 32'd6, 32'd0, 1'b0, 4'd3, 32'd42, 1'b0, 1'b0};
        tbl[1] = '{32'd3, 32'd5, 32'd100, 1'b1, 4'd9, 32'd115, 1'b0, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 4'hF, 32'hFFFF_FFFE, 1'b1, 1'b0};
        tbl[3] = '{32'h8000_0000, 32'd2, 32'd0, 1'b0, 4'd1, 32'd0, 1'b0, 1'b1};
        tbl[4] = '{32'd123, 32'd0, 32'd55, 1'b1, 4'd5, 32'd55, 1'b0, 1'b0};
        tbl[5] = '{32'd3, 32'h8000_0000, 32'd0, 1'b0, 4'd7, 32'h8000_0000, 1'b1, 1'b0};
        tbl[6] = '{32'h10, 32'h10, 32'hFFFF_FF00, 1'b1, 4'd12, 32'd0, 1'b0, 1'b1};
        tbl[7] = '{32'd9, 32'h10, 32'd0, 1'b0, 4'd2, 32'd144, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        a = '0; b = '0; acc = '0; accumulate = 1'b0; wa_in = '0;
        repeat (3) step();
        check("reset.outputs", 64'({busy, done, we_out, result, wa_out, flag_n, flag_z}), 64'(0));
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), tbl[i]);

        // start while busy is ignored
        start_op(32'd3, 32'h8000_0000, 32'd0, 1'b0, 4'd4);
        while (cyc < 10) step();
        start = 1'b1; a = 32'd1; b = 32'd1; wa_in = 4'd8;
        step();
        start = 1'b0;
        finish_op("busy_start", 33, 32'h8000_0000, 1'b1, 1'b0, 4'd4);

        // abort in RUN
        start_op(32'd5, 32'h8000_0000, 32'd0, 1'b0, 4'd2);
        while (cyc < 20) step();
        abort = 1'b1;
        #1 check("abort_run.done", 64'({done, we_out}), 64'(0));
        step();
        abort = 1'b0;
        check("abort_run.after", 64'({busy, done, result, flag_n, flag_z}),
              64'({1'b0, 1'b0, last_res, last_n, last_z}));
        expect_quiet("abort_run", 40);

        // abort in the DONE cycle suppresses the pulse and keeps the old result
        start_op(32'd3, 32'd6, 32'd0, 1'b0, 4'd6);
        while (!done && cyc < 40) step();
        check("abort_done.cycle", 64'(cyc), 64'(exp_cycle(32'd6)));
        abort = 1'b1;
        #1 check("abort_done.done", 64'({done, we_out}), 64'(0));
        step();
        abort = 1'b0;
        check("abort_done.after", 64'({busy, result, flag_n, flag_z}),
              64'({1'b0, last_res, last_n, last_z}));

        // reset in the middle of an operation
        start_op(32'd11, 32'h8000_0000, 32'd0, 1'b0, 4'd13);
        while (cyc < 15) step();
        rst_n = 1'b0;
        step();
        check("reset_mid.outputs", 64'({busy, done, we_out, result, wa_out, flag_n, flag_z}), 64'(0));
        rst_n = 1'b1;
        expect_quiet("reset_mid", 40);
        last_res = '0; last_n = 1'b0; last_z = 1'b0;

        // start with abort in IDLE
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort.busy", 64'(busy), 64'(0));
        expect_quiet("start_abort", 36);

        for (int i = 0; i < 20; i++) begin
            rv.a = $urandom; rv.acc = $urandom; rv.accum = 1'($urandom); rv.wa = 4'($urandom);
            rv.b = (i % 3 == 0) ? ($urandom >> $urandom_range(31, 0)) : $urandom;
            rv.exp_res = ref_mul(rv.a, rv.b, rv.acc, rv.accum);
            rv.exp_n = rv.exp_res[31];
            rv.exp_z = (rv.exp_res == 32'd0);
            run_op($sformatf("rand%0d", i), rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
